// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receiving end of a VGA link. Samples HS/VS/COLOR on pixel
// ticks, rebuilds pixel coordinates, measures line/frame timing, declares
// lock after consecutive good frames, keeps a sticky sync-error flag and
// captures the colour seen at one programmable probe pixel.
//
// Coordinate convention: the tick carrying an HS assertion edge is column 0
// of a line, and the line carrying a VS assertion edge is row 0 of a frame.
// Visibility, RX_X/RX_Y and the probe all use the position the counters take
// for the current tick (h_nxt/v_nxt). H_TOTAL_MEAS/V_TOTAL_MEAS use the
// position of the previous tick/line plus one.
module vga_rx_monitor #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SYNC_POL    = 0,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PIX_EN,
   input  logic        HS_IN,
   input  logic        VS_IN,
   input  logic [11:0] COLOR_IN,
   input  logic [9:0]  PROBE_X,
   input  logic [9:0]  PROBE_Y,
   output logic [9:0]  RX_X,
   output logic [9:0]  RX_Y,
   output logic        RX_ACTIVE,
   output logic        LOCKED,
   output logic [9:0]  H_TOTAL_MEAS,
   output logic [9:0]  V_TOTAL_MEAS,
   output logic [11:0] PROBE_COLOR,
   output logic        PROBE_VALID,
   output logic        FRAME_DONE,
   output logic [7:0]  FRAME_CNT,
   output logic        SYNC_ERR
);

   localparam logic [10:0] H_TOT    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [10:0] V_TOT    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [9:0]  H_ST     = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  H_EN     = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0]  V_ST     = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_EN     = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [9:0]  HSW      = 10'(H_SYNC);
   localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);
   localparam logic        SYNC_LVL = (SYNC_POL != 0);
   localparam logic [9:0]  CNT_MAX  = 10'h3FF;

   typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

   state_t      state;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [9:0]  hs_w;
   logic [7:0]  good_cnt;
   logic        hs_prev;
   logic        vs_prev;
   logic        hs_seen;
   logic        bad;

   logic        hs_a, vs_a, hs_edge, hs_fall, vs_edge;
   logic [10:0] h_sum, v_sum;
   logic [9:0]  h_nxt, v_nxt, x_nxt, y_nxt;
   logic        h_sat, v_sat, hper_err, hw_err, line_err, vper_ok;
   logic        vis, probe_hit;
   logic [7:0]  good_inc;

   // Edge detection, next counter positions and per-tick timing checks.
   always_comb begin
      hs_a     = (HS_IN == SYNC_LVL);
      vs_a     = (VS_IN == SYNC_LVL);
      hs_edge  = hs_a & ~hs_prev;
      hs_fall  = ~hs_a & hs_prev;
      vs_edge  = hs_edge & vs_a & ~vs_prev;
      h_sum    = {1'b0, h_cnt} + 11'd1;
      v_sum    = {1'b0, v_cnt} + 11'd1;
      h_nxt    = h_cnt;
      if (hs_edge)
         h_nxt = '0;
      else if (h_cnt != CNT_MAX)
         h_nxt = h_cnt + 10'd1;
      v_nxt    = v_cnt;
      if (vs_edge)
         v_nxt = '0;
      else if (hs_edge && (v_cnt != CNT_MAX))
         v_nxt = v_cnt + 10'd1;
      h_sat    = ~hs_edge & (h_cnt == CNT_MAX);
      v_sat    = hs_edge & ~vs_edge & (v_cnt == CNT_MAX);
      // The very first HS edge after reset has no meaningful period.
      hper_err = hs_edge & hs_seen & (h_sum != H_TOT);
      hw_err   = hs_fall & (hs_w != HSW);
      line_err = hper_err | hw_err | h_sat | v_sat;
      vper_ok  = (v_sum == V_TOT);
      vis      = (h_nxt >= H_ST) && (h_nxt <= H_EN) &&
                 (v_nxt >= V_ST) && (v_nxt <= V_EN);
      x_nxt    = h_nxt - H_ST;
      y_nxt    = v_nxt - V_ST;
      probe_hit = vis && (state == ST_LOCKED) &&
                  (x_nxt == PROBE_X) && (y_nxt == PROBE_Y);
      good_inc = good_cnt + 8'd1;
   end

   // Counters, measurements, probe capture and the lock state machine.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= ST_SEARCH;
         h_cnt        <= '0;
         v_cnt        <= '0;
         hs_w         <= '0;
         good_cnt     <= '0;
         hs_prev      <= 1'b0;
         vs_prev      <= 1'b0;
         hs_seen      <= 1'b0;
         bad          <= 1'b0;
         RX_X         <= '0;
         RX_Y         <= '0;
         RX_ACTIVE    <= 1'b0;
         LOCKED       <= 1'b0;
         H_TOTAL_MEAS <= '0;
         V_TOTAL_MEAS <= '0;
         PROBE_COLOR  <= '0;
         PROBE_VALID  <= 1'b0;
         FRAME_DONE   <= 1'b0;
         FRAME_CNT    <= '0;
         SYNC_ERR     <= 1'b0;
      end else begin
         FRAME_DONE  <= 1'b0;
         PROBE_VALID <= 1'b0;
         if (PIX_EN) begin
            hs_prev <= hs_a;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            if (hs_edge) begin
               H_TOTAL_MEAS <= h_sum[9:0];
               hs_seen      <= 1'b1;
               vs_prev      <= vs_a;
               hs_w         <= 10'd1;
            end else if (hs_a && (hs_w != CNT_MAX)) begin
               hs_w <= hs_w + 10'd1;
            end
            if (vs_edge) begin
               V_TOTAL_MEAS <= v_sum[9:0];
               FRAME_DONE   <= 1'b1;
               FRAME_CNT    <= FRAME_CNT + 8'd1;
            end
            if (vis) begin
               RX_X <= x_nxt;
               RX_Y <= y_nxt;
            end
            RX_ACTIVE <= vis && (state == ST_LOCKED);
            if (probe_hit) begin
               PROBE_COLOR <= COLOR_IN;
               PROBE_VALID <= 1'b1;
            end
            case (state)
               ST_SEARCH: begin
                  if (vs_edge) begin
                     state    <= ST_MEASURE;
                     good_cnt <= '0;
                     bad      <= 1'b0;
                  end
               end
               ST_MEASURE: begin
                  if (vs_edge) begin
                     bad <= 1'b0;
                     if (!bad && !line_err && vper_ok) begin
                        good_cnt <= good_inc;
                        if (good_inc == LOCK_N) begin
                           state  <= ST_LOCKED;
                           LOCKED <= 1'b1;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end else if (line_err) begin
                     bad <= 1'b1;
                  end
               end
               ST_LOCKED: begin
                  if (line_err || (vs_edge && !vper_ok)) begin
                     SYNC_ERR <= 1'b1;
                     LOCKED   <= 1'b0;
                     state    <= ST_SEARCH;
                  end
               end
               default: state <= ST_SEARCH;
            endcase
         end
      end
   end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receiving end of the VGA video interface.
- Samples HS/VS/COLOR as the display would, at the pixel-enable rate, and reconstructs pixel coordinates.
- Measures line and frame timing, declares lock, flags sticky sync errors and captures the colour at one programmable probe pixel.
- Sits beside ModuloVGA in self-checking benches and as an on-chip loopback monitor.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, HS pulse width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of HS_IN/VS_IN (0 = active-low)
LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
CLK  in  1  system clock
RST  in  1  reset
PIX_EN  in  1  pixel tick (ENClock); all sampling occurs only on CLK edges with PIX_EN=1
HS_IN  in  1  horizontal sync
VS_IN  in  1  vertical sync
COLOR_IN  in  12  pixel colour
PROBE_X  in  10  probe column, 0..H_ACTIVE-1
PROBE_Y  in  10  probe row, 0..V_ACTIVE-1
RX_X  out  10  reconstructed column, valid when RX_ACTIVE=1
RX_Y  out  10  reconstructed row, valid when RX_ACTIVE=1
RX_ACTIVE  out  1  current tick lies in the visible area and block is locked
LOCKED  out  1  timing lock
H_TOTAL_MEAS  out  10  ticks between the last two HS assertion edges
V_TOTAL_MEAS  out  10  lines between the last two VS assertion edges
PROBE_COLOR  out  12  colour captured at (PROBE_X, PROBE_Y)
PROBE_VALID  out  1  one-CLK pulse when PROBE_COLOR updates
FRAME_DONE  out  1  one-CLK pulse on each VS assertion edge
FRAME_CNT  out  8  VS assertion edges seen, wraps 255 -> 0
SYNC_ERR  out  1  sticky timing violation flag

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset: every output 0, all internal counters 0, state SEARCH. Reset mid-frame behaves identically, and SYNC_ERR is cleared only by RST.
- Ticks: nothing changes on cycles with PIX_EN=0, except that single-cycle pulses return to 0. All outputs are registered and update 1 CLK after the sampling tick.
- hs_a = (HS_IN==SYNC_POL). A HS edge is a tick with hs_a=1 whose previous tick had hs_a=0.
- h_cnt:
  - On a HS edge: H_TOTAL_MEAS <= h_cnt+1 and h_cnt <= 0.
  - Otherwise h_cnt increments, saturating at 1023.
  - Saturation is a timing error.
- HS width: ticks with hs_a=1 are counted. At HS deassertion, count != H_SYNC is a timing error.
- VS sampling: VS_IN is sampled only on HS-edge ticks, giving vs_a. A VS edge is vs_a=1 with the previous line's vs_a=0.
  - On a VS edge: V_TOTAL_MEAS <= v_cnt+1, v_cnt <= 0, FRAME_DONE pulses, FRAME_CNT++.
  - On other HS edges: v_cnt++, saturating at 1023.
- Visible area:
  - Active when h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] (144..783) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] (35..514).
  - RX_X = h_cnt-144 and RX_Y = v_cnt-35.
  - Outside active, RX_X/RX_Y hold their last values.
- H_TOTAL = 800 and V_TOTAL = 525, both derived from the parameters.
- State machine:
  - SEARCH: wait for a VS edge -> MEASURE with good_cnt=0. That first frame is never evaluated.
  - MEASURE:
    - A per-frame bad flag is set by any HS period != H_TOTAL (checked at each HS edge after the first in the frame), any HS width error, or saturation.
    - At a VS edge: if V_TOTAL_MEAS-to-be == V_TOTAL and bad flag is 0, then good_cnt++, else good_cnt <= 0. Bad flag is cleared.
    - good_cnt == LOCK_FRAMES -> LOCKED, with LOCKED=1 in the same update.
  - LOCKED: any HS period, HS width, VS period or saturation error -> SYNC_ERR <= 1, LOCKED <= 0, state SEARCH, in the same update.
  - Errors in SEARCH/MEASURE do not set SYNC_ERR.
- RX_ACTIVE = visible area AND LOCKED.
- Probe:
  - When RX_ACTIVE and coordinates equal PROBE_X/PROBE_Y at that tick, PROBE_COLOR <= COLOR_IN and PROBE_VALID pulses.
  - Probe inputs are sampled on the same tick.
  - Out-of-range probe values never match.
- Simultaneous HS edge and VS edge: the VS update takes precedence for v_cnt; the H update proceeds normally.

Test Plan:
- RST=1 for 10 CLK -> all outputs 0. Release with no PIX_EN -> outputs unchanged.
- Nominal 640x480 generator, PIX_EN every 4th CLK -> FRAME_DONE on each VS edge. LOCKED rises 1 CLK after the 3rd VS edge. H_TOTAL_MEAS=800, V_TOTAL_MEAS=525, SYNC_ERR=0.
- Locked, pattern colour = {RX_X[3:0], RX_Y[3:0], 4'hA}, probe (0,0) -> PROBE_COLOR=12'h00A with one PROBE_VALID per frame. Probe (639,479) -> 12'hFFA. Probe (640,0) -> never valid.
- Locked, one line stretched to 801 ticks -> H_TOTAL_MEAS=801, SYNC_ERR=1, LOCKED=0 within 1 CLK of that HS edge. After 3 more good VS edges LOCKED=1 and SYNC_ERR stays 1.
- Locked, HS pulse of 95 ticks -> SYNC_ERR=1. Separately, HS held deasserted -> h_cnt saturates, SYNC_ERR=1.
- RST asserted mid-frame while locked with SYNC_ERR=1 -> next CLK all outputs 0 including SYNC_ERR and FRAME_CNT. Relock as in the nominal scenario.
